imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/pa_riscv.sv | 34 +++
 rtl/imem_loader_pack.sv | 42 ++++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pa_riscv.sv
// Shared loader/ISA definitions: loader FSM states and the accepted opcode set.
package pa_riscv;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } ty_LOADER_STATE;

    typedef enum logic [6:0] {
        LW         = 7'b0000011,
        I_TYPE_ALU = 7'b0010011,
        SW         = 7'b0100011,
        R_TYPE_ALU = 7'b0110011,
        B_TYPE     = 7'b1100011,
        JAL        = 7'b1101111
    } ty_OPERAND;

    // True when the 7-bit opcode field belongs to the subset the core executes.
    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        ty_OPERAND op;
        op = ty_OPERAND'(opcode);
        case (op)
            LW, I_TYPE_ALU, SW, R_TYPE_ALU, B_TYPE, JAL: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Little-endian byte-to-word assembler: each push fills the lane selected by byte_idx.
module imem_loader_pack
    import pa_riscv::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_idx,
    output logic              complete_c,
    output logic [6:0]        next_opcode_c
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        byte_idx_q;

    // Word is complete when the byte for the top lane is accepted.
    always_comb begin
        complete_c    = push && (byte_idx_q == 2'd3);
        next_opcode_c = (byte_idx_q == 2'd0) ? din[6:0] : word_q[6:0];
    end

    // Lane write and byte index advance; clear restarts assembly at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            byte_idx_q <= 2'd0;
        end else if (clear) begin
            word_q     <= '0;
            byte_idx_q <= 2'd0;
        end else if (push) begin
            word_q[{byte_idx_q, 3'b000} +: BYTE_W] <= din;
            byte_idx_q                             <= byte_idx_q + 2'd1;
        end
    end

    assign word     = word_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, vetting each word's opcode,
// and holds the core in reset until a complete, legal image has been written.
module imem_loader
    import pa_riscv::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W:0]     i_numWords,
    input  logic                i_valid,
    input  logic [BYTE_W-1:0]   i_data,
    output logic                o_ready,
    output logic                o_imemWrEn,
    output logic [ADDR_W-1:0]   o_imemAddr,
    output logic [WORD_W-1:0]   o_imemWrData,
    output logic                o_cpuRstN,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [ADDR_W-1:0]   o_errorAddr
);

    localparam int unsigned NUM_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    ty_LOADER_STATE state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [NUM_W-1:0]  num_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              ready_q, wr_en_q, busy_q, done_q, error_q, cpu_rst_n_q;
    logic              ready_d, wr_en_d, busy_d, done_d, error_d, cpu_rst_n_d;

    logic [WORD_W-1:0] word;
    logic [1:0]        byte_idx;
    logic              complete_c;
    logic [6:0]        next_opcode_c;

    logic              start_ok_c;
    logic              hs_c;
    logic              num_zero_c;
    logic              num_over_c;
    logic              word_legal_c;
    logic              last_c;

    // Decode of handshake, start acceptance and per-word conditions.
    always_comb begin
        start_ok_c   = i_start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
        hs_c         = i_valid && ready_q;
        num_zero_c   = (i_numWords == '0);
        num_over_c   = (i_numWords > NUM_W'(DEPTH));
        word_legal_c = is_legal_opcode(word[6:0]);
        last_c       = ({1'b0, addr_q} == (num_q - NUM_W'(1)));
    end

    imem_loader_pack u_pack (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .clear         (start_ok_c),
        .push          (hs_c),
        .din           (i_data),
        .word          (word),
        .byte_idx      (byte_idx),
        .complete_c    (complete_c),
        .next_opcode_c (next_opcode_c)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    if (num_zero_c)      state_d = DONE;
                    else if (num_over_c) state_d = ERROR;
                    else                 state_d = RECV;
                end
            end
            RECV: begin
                if (complete_c) state_d = WRITE;
            end
            WRITE: begin
                if (!word_legal_c) state_d = ERROR;
                else if (last_c)   state_d = DONE;
                else               state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags align with it.
    always_comb begin
        ready_d     = 1'b0;
        wr_en_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        cpu_rst_n_d = 1'b0;
        case (state_d)
            RECV: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            WRITE: begin
                busy_d  = 1'b1;
                wr_en_d = is_legal_opcode(next_opcode_c);
            end
            DONE: begin
                done_d      = 1'b1;
                cpu_rst_n_d = 1'b1;
            end
            ERROR: begin
                error_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Word count, write address and first-fault address tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_q      <= '0;
            addr_q     <= '0;
            err_addr_q <= '0;
        end else if (start_ok_c) begin
            num_q      <= i_numWords;
            addr_q     <= '0;
            err_addr_q <= '0;
        end else if (state_q == WRITE) begin
            if (!word_legal_c) err_addr_q <= addr_q;
            else if (!last_c)  addr_q     <= addr_q + ADDR_W'(1);
        end
    end

    assign o_ready      = ready_q;
    assign o_imemWrEn   = wr_en_q;
    assign o_imemAddr   = addr_q;
    assign o_imemWrData = word;
    assign o_cpuRstN    = cpu_rst_n_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_errorAddr  = err_addr_q;

endmodule
